fetch_queue: RTL
================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, instruction word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, PC and instruction-memory address width.
REQ-003 SHALL have parameter DEPTH, default 4, queue entries; power of two, at least 2.
REQ-004 SHALL have parameter RESET_PC, default 0, first fetch address after reset.
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port imem_req, output, 1, fetch request valid.
REQ-008 SHALL have port imem_addr, output, ADDR_WIDTH, fetch address.
REQ-009 SHALL have port imem_gnt, input, 1, memory accepts the request this cycle.
REQ-010 SHALL have port imem_rvalid, input, 1, response valid, exactly one cycle after an accepted request.
REQ-011 SHALL have port imem_rdata, input, DATA_WIDTH, response instruction.
REQ-012 SHALL have port instr_valid, output, 1, head entry valid toward decode.
REQ-013 SHALL have port instr, output, DATA_WIDTH, head instruction.
REQ-014 SHALL have port instr_pc, output, ADDR_WIDTH, PC of the head instruction.
REQ-015 SHALL have port instr_ready, input, 1, decode consumes the head entry this cycle.
REQ-016 SHALL have port redirect, input, 1, branch/jal/jalr taken; flush and refetch.
REQ-017 SHALL have port redirect_pc, input, ADDR_WIDTH, new fetch target.
REQ-018 SHALL have port halt, input, 1, stop issuing new requests.

Function
REQ-019 SHALL implement a state machine with states BOOT, RUN and HALT; BOOT lasts exactly one cycle after reset release, then moves to HALT if halt=1, else RUN.
REQ-020 SHALL move RUN->HALT when halt=1 and HALT->RUN when halt=0; transitions take effect on the next cycle.
REQ-021 SHALL assert imem_req only in RUN, only with redirect=0, and only when count + inflight < DEPTH; imem_addr SHALL equal the fetch PC.
REQ-022 SHALL advance the fetch PC by 4 on each accepted request (imem_req & imem_gnt), wrapping modulo 2^ADDR_WIDTH.
REQ-023 SHALL record each accepted request's PC and write {imem_rdata, PC} to the queue tail on the following imem_rvalid; credit gating guarantees space, so overflow SHALL never occur.
REQ-024 SHALL pop the head entry on instr_valid & instr_ready; instr_valid SHALL equal (count != 0); push and pop in the same cycle SHALL leave count unchanged, including when full.
REQ-025 SHALL, on redirect=1: clear the queue (count=0), load the fetch PC with redirect_pc, and discard the response to any request still in flight; the first request at redirect_pc SHALL be issued no earlier than the next cycle.
REQ-026 SHALL treat a consume handshake in the redirect cycle as completed; the entry is not re-presented.
REQ-027 SHALL drop an imem_rvalid arriving in the redirect cycle.
REQ-028 SHALL apply redirect in HALT as well (flush and PC update) while remaining in HALT.
REQ-029 SHALL accept in-flight responses while in HALT.
REQ-030 SHALL ignore imem_rvalid when no request is outstanding.
REQ-031 SHALL have no combinational path from imem_rvalid/imem_rdata to instr_valid/instr, except as allowed under Configuration.

Reset
REQ-032 SHALL, on rst=0, asynchronously set: state=BOOT, fetch PC=RESET_PC, count=0, inflight=0, kill flag=0, imem_req=0, instr_valid=0; instr and instr_pc are don't-care while invalid.
REQ-033 SHALL abandon any outstanding request when reset is asserted mid-operation; a response arriving after reset release SHALL be ignored.

Configuration
REQ-034 SHALL support macro FETCH_QUEUE_BYPASS_EN; when defined, with an empty queue and a valid, non-killed response, the response SHALL drive instr/instr_pc with instr_valid=1 in the same cycle, and SHALL NOT be written to the queue if instr_ready=1.
REQ-035 SHALL, without FETCH_QUEUE_BYPASS_EN, always write the response to the queue, making it visible at the earliest one cycle later.

Verification
REQ-036 Reset release, RESET_PC=0x100, gnt=1, ready=1 -> requests 0x100, 0x104, 0x108 on consecutive cycles; instr_pc follows in order.
REQ-037 DEPTH=4, ready=0, gnt=1 -> exactly 4 requests issued, then imem_req=0 and count=4; ready=1 for one cycle -> one new request.
REQ-038 Redirect to 0x200 in the same cycle as rvalid for 0x10C -> 0x10C never presented; queue empty; next request 0x200.
REQ-039 halt=1 with one request in flight -> response is queued, no further requests; halt=0 -> requests resume at the next sequential PC.
REQ-040 Fetch PC=0xFFFFFFFC, ADDR_WIDTH=32 -> next request address 0x00000000.
REQ-041 With FETCH_QUEUE_BYPASS_EN, empty queue, ready=1 -> instr_valid high in the rvalid cycle and count stays 0; without the macro -> instr_valid rises one cycle later.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch unit with a small credit-gated queue.
// Issues sequential fetch requests, buffers {instr, pc} pairs toward decode,
// flushes and refetches on redirect, and stops issuing while halted.
// Optional macro FETCH_QUEUE_BYPASS_EN: an empty queue forwards a response
// straight to decode in the cycle it arrives.
// Handshakes: imem_req/imem_gnt transfer a request in the cycle both are high;
// instr_valid/instr_ready pop the head entry in the cycle both are high.
// The response to an accepted request arrives exactly one cycle later.
module fetch_queue #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req,
  output logic [ADDR_WIDTH-1:0]    imem_addr,
  input  logic                     imem_gnt,
  input  logic                     imem_rvalid,
  input  logic [DATA_WIDTH-1:0]    imem_rdata,
  output logic                     instr_valid,
  output logic [DATA_WIDTH-1:0]    instr,
  output logic [ADDR_WIDTH-1:0]    instr_pc,
  input  logic                     instr_ready,
  input  logic                     redirect,
  input  logic [ADDR_WIDTH-1:0]    redirect_pc,
  input  logic                     halt,
  output logic [1:0]               dbg_state,
  output logic [$clog2(DEPTH):0]   dbg_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]         count_q, count_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic                  inflight_q, inflight_d;
  logic                  kill_q, kill_d;

  logic [DATA_WIDTH-1:0] mem_data [DEPTH];
  logic [ADDR_WIDTH-1:0] mem_pc   [DEPTH];

  logic credit, accept, rsp_ok, push, pop, bypass;

  assign dbg_state = state_q;
  assign dbg_count = count_q;

  // Request side: issue only in RUN, never during a redirect, and only with a free slot.
  always_comb begin
    credit    = (count_q + CW'(inflight_q)) < DEPTH_C;
    imem_req  = (state_q == RUN) && !redirect && credit;
    imem_addr = pc_q;
    accept    = imem_req && imem_gnt;
    rsp_ok    = imem_rvalid && inflight_q && !kill_q && !redirect;
  end

  // Decode side: head of queue, or the live response when bypass is built in.
  always_comb begin
    instr_valid = (count_q != '0);
    instr       = mem_data[rd_ptr_q];
    instr_pc    = mem_pc[rd_ptr_q];
    bypass      = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
    if ((count_q == '0) && rsp_ok) begin
      bypass      = 1'b1;
      instr_valid = 1'b1;
      instr       = imem_rdata;
      instr_pc    = rsp_pc_q;
    end
`endif
    pop  = instr_valid && instr_ready && (count_q != '0);
    push = rsp_ok && !(bypass && instr_ready);
  end

  // Next-state: FSM, fetch PC, in-flight tracking, queue pointers; redirect overrides.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    rsp_pc_d   = rsp_pc_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    inflight_d = accept;
    kill_d     = 1'b0;

    case (state_q)
      BOOT:    state_d = halt ? HALT : RUN;
      RUN:     if (halt)  state_d = HALT;
      HALT:    if (!halt) state_d = RUN;
      default: state_d = BOOT;
    endcase

    if (accept) begin
      pc_d     = pc_q + ADDR_WIDTH'(4);
      rsp_pc_d = pc_q;
    end

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    count_d = count_q + CW'(push) - CW'(pop);

    // Flush: the in-flight response lands in this very cycle and is dropped above;
    // the kill flag records that a response was discarded.
    if (redirect) begin
      pc_d       = redirect_pc;
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      inflight_d = 1'b0;
      kill_d     = inflight_q;
    end
  end

  // Control state register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      rsp_pc_q   <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      rsp_pc_q   <= rsp_pc_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      inflight_q <= inflight_d;
      kill_q     <= kill_d;
    end
  end

  // Queue storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr_q] <= imem_rdata;
      mem_pc[wr_ptr_q]   <= rsp_pc_q;
    end
  end

endmodule
